// File: rtl/pong_pkg.sv
// Shared types for the pong referee: FSM states, bounce event codes, player IDs.
package pong_pkg;

    localparam int unsigned BOUNCE_W = 2;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_SCORED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    typedef enum logic [BOUNCE_W-1:0] {
        BOUNCE_NONE   = 2'd0,
        BOUNCE_PADDLE = 2'd1,
        BOUNCE_WALL   = 2'd2,
        BOUNCE_SERVE  = 2'd3
    } bounce_e;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_e;

endpackage

// File: rtl/pong_referee_if.sv
// Geometry inputs and event/score outputs between the pong referee and its neighbours.
interface pong_referee_if #(
    parameter int unsigned POS_W   = 10,
    parameter int unsigned SIZE_W  = 8,
    parameter int unsigned SCORE_W = 4
);
    logic               frame_tick;
    logic               restart;
    logic [POS_W-1:0]   ball_pos_x;
    logic [POS_W-1:0]   ball_pos_y;
    logic [SIZE_W-1:0]  ball_size_x;
    logic [SIZE_W-1:0]  ball_size_y;
    logic [POS_W-1:0]   paddle_1_pos_x;
    logic [POS_W-1:0]   paddle_1_pos_y;
    logic [POS_W-1:0]   paddle_2_pos_x;
    logic [POS_W-1:0]   paddle_2_pos_y;
    logic [SIZE_W-1:0]  paddle_1_size_x;
    logic [SIZE_W-1:0]  paddle_1_size_y;
    logic [SIZE_W-1:0]  paddle_2_size_x;
    logic [SIZE_W-1:0]  paddle_2_size_y;
    logic [1:0]         bounce;
    logic               hit_paddle;
    logic [SCORE_W-1:0] score_player_1;
    logic [SCORE_W-1:0] score_player_2;
    logic               serving;
    logic               game_over;
    logic               winner;

    // Position/timing source side
    modport master (
        output frame_tick, restart,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        output paddle_1_pos_x, paddle_1_pos_y, paddle_2_pos_x, paddle_2_pos_y,
        output paddle_1_size_x, paddle_1_size_y, paddle_2_size_x, paddle_2_size_y,
        input  bounce, hit_paddle, score_player_1, score_player_2,
        input  serving, game_over, winner
    );

    // Referee side
    modport slave (
        input  frame_tick, restart,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        input  paddle_1_pos_x, paddle_1_pos_y, paddle_2_pos_x, paddle_2_pos_y,
        input  paddle_1_size_x, paddle_1_size_y, paddle_2_size_x, paddle_2_size_y,
        output bounce, hit_paddle, score_player_1, score_player_2,
        output serving, game_over, winner
    );

endinterface

// File: rtl/rect_hit_detect.sv
// Combinational ball-vs-paddle contact term; RIGHT_SIDE selects which ball edge faces the paddle.
module rect_hit_detect #(
    parameter int unsigned POS_W      = 10,
    parameter int unsigned SIZE_W     = 8,
    parameter bit          RIGHT_SIDE = 1'b0
) (
    input  logic [POS_W:0]    ball_x_lo,
    input  logic [POS_W:0]    ball_x_hi,
    input  logic [POS_W:0]    ball_cy,
    input  logic [POS_W-1:0]  pad_pos_x,
    input  logic [POS_W-1:0]  pad_pos_y,
    input  logic [SIZE_W-1:0] pad_size_x,
    input  logic [SIZE_W-1:0] pad_size_y,
    output logic              hit_c
);
    localparam int unsigned EXT_W = POS_W + 1;

    logic [EXT_W-1:0] pad_x_lo;
    logic [EXT_W-1:0] pad_x_hi;
    logic [EXT_W-1:0] pad_y_lo;
    logic [EXT_W-1:0] pad_y_hi;
    logic             horiz_c;
    logic             vert_c;

    // Left paddle is hit by the ball's left edge, right paddle by its right edge
    always_comb begin
        pad_x_lo = EXT_W'(pad_pos_x);
        pad_x_hi = EXT_W'(pad_pos_x) + EXT_W'(pad_size_x);
        pad_y_lo = EXT_W'(pad_pos_y);
        pad_y_hi = EXT_W'(pad_pos_y) + EXT_W'(pad_size_y);
        horiz_c  = RIGHT_SIDE ? (ball_x_hi >= pad_x_lo) : (ball_x_lo <= pad_x_hi);
        vert_c   = (ball_cy >= pad_y_lo) && (ball_cy <= pad_y_hi);
        hit_c    = horiz_c && vert_c;
    end

endmodule

// File: rtl/pong_referee.sv
// Pong referee: per-frame goal/wall/paddle evaluation, scoring, serve timing and game over.
module pong_referee
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_X     = 640,
    parameter int unsigned SCREEN_Y     = 480,
    parameter int unsigned MARGIN       = 5,
    parameter int unsigned POS_W        = 10,
    parameter int unsigned SIZE_W       = 8,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic          clock,
    input  logic          reset_n,
    pong_referee_if.slave bus
);
    localparam int unsigned EXT_W = POS_W + 1;
    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0] score_1_q,   score_1_d;
    logic [SCORE_W-1:0] score_2_q,   score_2_d;
    logic               contact_1_q, contact_1_d;
    logic               contact_2_q, contact_2_d;
    player_e            scorer_q,    scorer_d;
    bounce_e            bounce_q,    bounce_d;
    player_e            hit_paddle_q, hit_paddle_d;
    logic               serving_q,   serving_d;
    logic               game_over_q, game_over_d;
    player_e            winner_q,    winner_d;

    logic [EXT_W-1:0]   ball_x_lo;
    logic [EXT_W-1:0]   ball_x_hi;
    logic [EXT_W-1:0]   ball_y_lo;
    logic [EXT_W-1:0]   ball_y_hi;
    logic [EXT_W-1:0]   ball_cy;
    logic               goal_r_c;
    logic               goal_l_c;
    logic               wall_c;
    logic               p1_c;
    logic               p2_c;
    logic               serve_done_c;
    logic [SCORE_W-1:0] scorer_pts_c;
    logic               win_c;

    // Ball extents widened by one bit so the sums cannot overflow
    always_comb begin
        ball_x_lo = EXT_W'(bus.ball_pos_x);
        ball_x_hi = EXT_W'(bus.ball_pos_x) + EXT_W'(bus.ball_size_x);
        ball_y_lo = EXT_W'(bus.ball_pos_y);
        ball_y_hi = EXT_W'(bus.ball_pos_y) + EXT_W'(bus.ball_size_y);
        ball_cy   = EXT_W'(bus.ball_pos_y) + EXT_W'(bus.ball_size_y >> 1);
        goal_r_c  = ball_x_hi >= EXT_W'(SCREEN_X - MARGIN);
        goal_l_c  = ball_x_lo <= EXT_W'(MARGIN);
        wall_c    = (ball_y_hi >= EXT_W'(SCREEN_Y - MARGIN)) || (ball_y_lo <= EXT_W'(MARGIN));
    end

    rect_hit_detect #(.POS_W(POS_W), .SIZE_W(SIZE_W), .RIGHT_SIDE(1'b0)) u_hit_p1 (
        .ball_x_lo  (ball_x_lo),
        .ball_x_hi  (ball_x_hi),
        .ball_cy    (ball_cy),
        .pad_pos_x  (bus.paddle_1_pos_x),
        .pad_pos_y  (bus.paddle_1_pos_y),
        .pad_size_x (bus.paddle_1_size_x),
        .pad_size_y (bus.paddle_1_size_y),
        .hit_c      (p1_c)
    );

    rect_hit_detect #(.POS_W(POS_W), .SIZE_W(SIZE_W), .RIGHT_SIDE(1'b1)) u_hit_p2 (
        .ball_x_lo  (ball_x_lo),
        .ball_x_hi  (ball_x_hi),
        .ball_cy    (ball_cy),
        .pad_pos_x  (bus.paddle_2_pos_x),
        .pad_pos_y  (bus.paddle_2_pos_y),
        .pad_size_x (bus.paddle_2_size_x),
        .pad_size_y (bus.paddle_2_size_y),
        .hit_c      (p2_c)
    );

    // Serve expiry and "this point wins the game" terms
    always_comb begin
        serve_done_c = (serve_cnt_q == CNT_W'(SERVE_FRAMES - 1));
        scorer_pts_c = (scorer_q == PLAYER_1) ? score_1_q : score_2_q;
        win_c        = (scorer_pts_c == SCORE_W'(WIN_SCORE - 1));
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SERVE:     if (bus.frame_tick && serve_done_c) state_d = ST_PLAY;
            ST_PLAY:      if (bus.frame_tick && (goal_r_c || goal_l_c)) state_d = ST_SCORED;
            ST_SCORED:    state_d = win_c ? ST_GAME_OVER : ST_SERVE;
            ST_GAME_OVER: if (bus.restart) state_d = ST_SERVE;
            default:      state_d = ST_SERVE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        serve_cnt_d  = serve_cnt_q;
        score_1_d    = score_1_q;
        score_2_d    = score_2_q;
        contact_1_d  = contact_1_q;
        contact_2_d  = contact_2_q;
        scorer_d     = scorer_q;
        winner_d     = winner_q;
        bounce_d     = BOUNCE_NONE;
        hit_paddle_d = PLAYER_1;
        serving_d    = (state_d == ST_SERVE);
        game_over_d  = (state_d == ST_GAME_OVER);
        case (state_q)
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (serve_done_c) begin
                        bounce_d    = BOUNCE_SERVE;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (bus.frame_tick) begin
                    if (goal_r_c) begin
                        scorer_d = PLAYER_1;
                    end else if (goal_l_c) begin
                        scorer_d = PLAYER_2;
                    end else begin
                        if (wall_c) begin
                            bounce_d = BOUNCE_WALL;
                        end else if (p1_c && !contact_1_q) begin
                            bounce_d     = BOUNCE_PADDLE;
                            hit_paddle_d = PLAYER_1;
                            contact_1_d  = 1'b1;
                        end else if (p2_c && !contact_2_q) begin
                            bounce_d     = BOUNCE_PADDLE;
                            hit_paddle_d = PLAYER_2;
                            contact_2_d  = 1'b1;
                        end
                        if (!p1_c) contact_1_d = 1'b0;
                        if (!p2_c) contact_2_d = 1'b0;
                    end
                end
            end
            ST_SCORED: begin
                if (scorer_q == PLAYER_1) begin
                    score_1_d = score_1_q + SCORE_W'(1);
                end else begin
                    score_2_d = score_2_q + SCORE_W'(1);
                end
                contact_1_d = 1'b0;
                contact_2_d = 1'b0;
                serve_cnt_d = '0;
                if (win_c) winner_d = scorer_q;
            end
            ST_GAME_OVER: begin
                serve_cnt_d = '0;
                if (bus.restart) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    winner_d  = PLAYER_1;
                end
            end
            default: begin
                serve_cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            serve_cnt_q  <= '0;
            score_1_q    <= '0;
            score_2_q    <= '0;
            contact_1_q  <= 1'b0;
            contact_2_q  <= 1'b0;
            scorer_q     <= PLAYER_1;
            bounce_q     <= BOUNCE_NONE;
            hit_paddle_q <= PLAYER_1;
            serving_q    <= 1'b1;
            game_over_q  <= 1'b0;
            winner_q     <= PLAYER_1;
        end else begin
            serve_cnt_q  <= serve_cnt_d;
            score_1_q    <= score_1_d;
            score_2_q    <= score_2_d;
            contact_1_q  <= contact_1_d;
            contact_2_q  <= contact_2_d;
            scorer_q     <= scorer_d;
            bounce_q     <= bounce_d;
            hit_paddle_q <= hit_paddle_d;
            serving_q    <= serving_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign bus.bounce         = bounce_q;
    assign bus.hit_paddle     = hit_paddle_q;
    assign bus.score_player_1 = score_1_q;
    assign bus.score_player_2 = score_2_q;
    assign bus.serving        = serving_q;
    assign bus.game_over      = game_over_q;
    assign bus.winner         = winner_q;

endmodule

// File: tb/tb_pong_referee.sv
// Bench for pong_referee: directed sequences, a vector table and a random run against a rule model.
module tb_pong_referee;

    localparam int SF   = 60;
    localparam int WIN  = 9;
    localparam int M_SERVE  = 0;
    localparam int M_PLAY   = 1;
    localparam int M_SCORED = 2;
    localparam int M_OVER   = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    pong_referee_if bus  ();
    pong_referee_if bus1 ();

    pong_referee dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    pong_referee #(.SERVE_FRAMES(1)) dut_sf1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, expressed in game terms
    int m_mode, m_cnt, m_s1, m_s2, m_scorer, m_winner, m_bounce, m_hit;
    bit m_c1, m_c2;

    typedef struct {
        int bx, by, bsx, bsy;
        int p1x, p1y, p1sx, p1sy;
        int p2x, p2y, p2sx, p2sy;
        int eb, eh, eg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_SERVE; m_cnt = 0; m_s1 = 0; m_s2 = 0;
        m_scorer = 0; m_winner = 0; m_bounce = 0; m_hit = 0;
        m_c1 = 0; m_c2 = 0;
    endtask

    // One clock of the game rules, using the inputs present at the edge
    task automatic model_step();
        int bx, by, bsx, bsy, cy;
        int p1x, p1y, p1sx, p1sy, p2x, p2y, p2sx, p2sy;
        bit gr, gl, wall, p1, p2, tick;
        if (!reset_n) begin
            model_reset();
            return;
        end
        bx = int'(bus.ball_pos_x);   by = int'(bus.ball_pos_y);
        bsx = int'(bus.ball_size_x); bsy = int'(bus.ball_size_y);
        p1x = int'(bus.paddle_1_pos_x);   p1y = int'(bus.paddle_1_pos_y);
        p1sx = int'(bus.paddle_1_size_x); p1sy = int'(bus.paddle_1_size_y);
        p2x = int'(bus.paddle_2_pos_x);   p2y = int'(bus.paddle_2_pos_y);
        p2sx = int'(bus.paddle_2_size_x); p2sy = int'(bus.paddle_2_size_y);
        tick = bus.frame_tick;
        cy   = by + bsy / 2;
        gr   = (bx + bsx) >= (640 - 5);
        gl   = bx <= 5;
        wall = ((by + bsy) >= (480 - 5)) || (by <= 5);
        p1   = (bx <= p1x + p1sx) && (cy >= p1y) && (cy <= p1y + p1sy);
        p2   = (bx + bsx >= p2x) && (cy >= p2y) && (cy <= p2y + p2sy);
        m_bounce = 0;
        m_hit    = 0;
        case (m_mode)
            M_SERVE: if (tick) begin
                if (m_cnt == SF - 1) begin
                    m_bounce = 3; m_cnt = 0; m_mode = M_PLAY;
                end else begin
                    m_cnt++;
                end
            end
            M_PLAY: if (tick) begin
                if (gr) begin
                    m_scorer = 0; m_mode = M_SCORED;
                end else if (gl) begin
                    m_scorer = 1; m_mode = M_SCORED;
                end else begin
                    if (wall) m_bounce = 2;
                    else if (p1 && !m_c1) begin m_bounce = 1; m_hit = 0; m_c1 = 1; end
                    else if (p2 && !m_c2) begin m_bounce = 1; m_hit = 1; m_c2 = 1; end
                    if (!p1) m_c1 = 0;
                    if (!p2) m_c2 = 0;
                end
            end
            M_SCORED: begin
                int pts;
                if (m_scorer == 0) begin m_s1++; pts = m_s1; end
                else begin m_s2++; pts = m_s2; end
                m_c1 = 0; m_c2 = 0;
                if (pts == WIN) begin m_winner = m_scorer; m_mode = M_OVER; end
                else m_mode = M_SERVE;
            end
            default: if (bus.restart) begin
                m_s1 = 0; m_s2 = 0; m_mode = M_SERVE;
            end
        endcase
    endtask

    task automatic check_all();
        check("bounce", int'(bus.bounce), m_bounce);
        if (m_bounce == 1) check("hit_paddle", int'(bus.hit_paddle), m_hit);
        check("score_p1", int'(bus.score_player_1), m_s1);
        check("score_p2", int'(bus.score_player_2), m_s2);
        check("serving", int'(bus.serving), (m_mode == M_SERVE) ? 1 : 0);
        check("game_over", int'(bus.game_over), (m_mode == M_OVER) ? 1 : 0);
        if (m_mode == M_OVER) check("winner", int'(bus.winner), m_winner);
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic tick_step();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_ball(input int x, input int y, input int sx, input int sy);
        bus.ball_pos_x = 10'(x); bus.ball_pos_y = 10'(y);
        bus.ball_size_x = 8'(sx); bus.ball_size_y = 8'(sy);
    endtask

    task automatic set_p1(input int x, input int y, input int sx, input int sy);
        bus.paddle_1_pos_x = 10'(x); bus.paddle_1_pos_y = 10'(y);
        bus.paddle_1_size_x = 8'(sx); bus.paddle_1_size_y = 8'(sy);
    endtask

    task automatic set_p2(input int x, input int y, input int sx, input int sy);
        bus.paddle_2_pos_x = 10'(x); bus.paddle_2_pos_y = 10'(y);
        bus.paddle_2_size_x = 8'(sx); bus.paddle_2_size_y = 8'(sy);
    endtask

    task automatic neutral();
        set_ball(300, 200, 10, 10);
        set_p1(10, 0, 10, 20);
        set_p2(620, 0, 10, 20);
    endtask

    task automatic go_play();
        neutral();
        for (int i = 0; i < 300 && m_mode != M_PLAY; i++) tick_step();
        check("go_play_reached", (m_mode == M_PLAY) ? 1 : 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bounce"}, int'(bus.bounce), 0);
        check({tag, "_hit"}, int'(bus.hit_paddle), 0);
        check({tag, "_s1"}, int'(bus.score_player_1), 0);
        check({tag, "_s2"}, int'(bus.score_player_2), 0);
        check({tag, "_serving"}, int'(bus.serving), 1);
        check({tag, "_game_over"}, int'(bus.game_over), 0);
        check({tag, "_winner"}, int'(bus.winner), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, s1b, s2b;
        bus.frame_tick = 1'b0; bus.restart = 1'b0;
        bus1.frame_tick = 1'b0; bus1.restart = 1'b0;
        bus1.ball_pos_x = 10'd300; bus1.ball_pos_y = 10'd200;
        bus1.ball_size_x = 8'd10; bus1.ball_size_y = 8'd10;
        bus1.paddle_1_pos_x = 10'd10; bus1.paddle_1_pos_y = 10'd0;
        bus1.paddle_1_size_x = 8'd10; bus1.paddle_1_size_y = 8'd20;
        bus1.paddle_2_pos_x = 10'd620; bus1.paddle_2_pos_y = 10'd0;
        bus1.paddle_2_size_x = 8'd10; bus1.paddle_2_size_y = 8'd20;
        neutral();
        model_reset();

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // SERVE_FRAMES=1 serves on its first tick
        bus1.frame_tick = 1'b1;
        step();
        bus1.frame_tick = 1'b0;
        check("sf1_serve_pulse", int'(bus1.bounce), 3);
        check("sf1_serving", int'(bus1.serving), 0);
        step();
        check("sf1_pulse_len", int'(bus1.bounce), 0);

        // Full serve: 59 quiet ticks then the serve pulse on tick 60
        for (int i = 1; i <= SF; i++) begin
            tick_step();
            if (i < SF) begin
                check("serve_quiet", int'(bus.bounce), 0);
                check("serve_serving", int'(bus.serving), 1);
            end else begin
                check("serve_pulse", int'(bus.bounce), 3);
            end
        end
        step();
        check("serve_pulse_len", int'(bus.bounce), 0);
        check("play_serving", int'(bus.serving), 0);

        // Top wall
        set_ball(300, 3, 10, 10);
        tick_step();
        check("wall_bounce", int'(bus.bounce), 2);
        neutral();
        step();
        check("wall_len", int'(bus.bounce), 0);
        check("wall_no_score", int'(bus.score_player_1) + int'(bus.score_player_2), 0);

        // Paddle 1 held for three ticks gives one hit; leave and return gives another
        set_p1(10, 190, 10, 30);
        set_ball(20, 200, 10, 10);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick_step();
            if (bus.bounce == 2'd1 && bus.hit_paddle == 1'b0) pulses++;
            step();
            check("no_tick_no_event", int'(bus.bounce), 0);
        end
        check("p1_single_pulse", pulses, 1);
        set_ball(300, 200, 10, 10);
        tick_step();
        set_ball(20, 200, 10, 10);
        tick_step();
        check("p1_rehit", int'(bus.bounce), 1);
        check("p1_rehit_id", int'(bus.hit_paddle), 0);

        // Vector table, each entry evaluated from a cleared contact state
        vecs.push_back('{300,470,10,5,   10,0,10,20,    620,0,10,20,   2,0,0});
        vecs.push_back('{300,469,10,5,   10,0,10,20,    620,0,10,20,   0,0,0});
        vecs.push_back('{300,5,10,10,    10,0,10,20,    620,0,10,20,   2,0,0});
        vecs.push_back('{300,6,10,10,    10,0,10,20,    620,0,10,20,   0,0,0});
        vecs.push_back('{20,190,10,10,   10,195,10,10,  620,0,10,20,   1,0,0});
        vecs.push_back('{21,190,10,10,   10,195,10,10,  620,0,10,20,   0,0,0});
        vecs.push_back('{20,190,10,10,   10,196,10,10,  620,0,10,20,   0,0,0});
        vecs.push_back('{20,190,10,10,   10,185,10,10,  620,0,10,20,   1,0,0});
        vecs.push_back('{610,200,10,10,  10,0,10,20,    620,190,10,30, 1,1,0});
        vecs.push_back('{609,200,10,10,  10,0,10,20,    620,190,10,30, 0,0,0});
        vecs.push_back('{20,3,10,10,     10,0,10,20,    620,0,10,20,   2,0,0});
        vecs.push_back('{20,200,250,10,  10,190,10,30,  260,190,10,30, 1,0,0});
        vecs.push_back('{625,200,10,10,  10,0,10,20,    620,0,10,20,   0,0,1});
        vecs.push_back('{624,200,10,10,  10,0,10,20,    620,0,10,20,   0,0,0});
        vecs.push_back('{5,200,10,10,    10,0,10,20,    620,0,10,20,   0,0,2});
        vecs.push_back('{6,200,10,10,    10,0,10,20,    620,0,10,20,   0,0,0});
        foreach (vecs[k]) begin
            neutral();
            tick_step();
            s1b = int'(bus.score_player_1);
            s2b = int'(bus.score_player_2);
            set_ball(vecs[k].bx, vecs[k].by, vecs[k].bsx, vecs[k].bsy);
            set_p1(vecs[k].p1x, vecs[k].p1y, vecs[k].p1sx, vecs[k].p1sy);
            set_p2(vecs[k].p2x, vecs[k].p2y, vecs[k].p2sx, vecs[k].p2sy);
            tick_step();
            check($sformatf("vec%0d_bounce", k), int'(bus.bounce), vecs[k].eb);
            if (vecs[k].eb == 1) check($sformatf("vec%0d_hit", k), int'(bus.hit_paddle), vecs[k].eh);
            if (vecs[k].eg != 0) begin
                neutral();
                step();
                step();
                check($sformatf("vec%0d_s1", k), int'(bus.score_player_1), s1b + (vecs[k].eg == 1 ? 1 : 0));
                check($sformatf("vec%0d_s2", k), int'(bus.score_player_2), s2b + (vecs[k].eg == 2 ? 1 : 0));
                check($sformatf("vec%0d_serving", k), int'(bus.serving), 1);
                go_play();
            end
        end

        // Right goal while paddle 2 also overlaps: goal wins
        neutral();
        tick_step();
        s1b = int'(bus.score_player_1);
        set_ball(626, 200, 10, 10);
        set_p2(620, 190, 10, 30);
        tick_step();
        check("goal_r_no_paddle", int'(bus.bounce), 0);
        neutral();
        step();
        step();
        check("goal_r_score", int'(bus.score_player_1), s1b + 1);
        check("goal_r_serving", int'(bus.serving), 1);

        // Reset at serve count 30, then the serve needs the full 60 ticks again
        for (int i = 0; i < 30; i++) tick_step();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("mid_reset");
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= SF; i++) begin
            tick_step();
            check(i < SF ? "reserve_quiet" : "reserve_pulse", int'(bus.bounce), i < SF ? 0 : 3);
        end

        // Nine left goals end the game for player 2
        for (int g = 0; g < WIN; g++) begin
            go_play();
            set_ball(0, 200, 10, 10);
            tick_step();
            check("goal_l_no_event", int'(bus.bounce), 0);
            neutral();
            step();
            step();
            if (g == 0) begin
                bus.restart = 1'b1;
                step();
                bus.restart = 1'b0;
                check("restart_ignored", int'(bus.score_player_2), 1);
            end
        end
        check("final_s2", int'(bus.score_player_2), 9);
        check("final_game_over", int'(bus.game_over), 1);
        check("final_winner", int'(bus.winner), 1);
        check("final_serving", int'(bus.serving), 0);
        set_ball(0, 200, 10, 10);
        for (int i = 0; i < 3; i++) begin
            tick_step();
            check("over_frozen_s2", int'(bus.score_player_2), 9);
            check("over_no_bounce", int'(bus.bounce), 0);
        end
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check("restart_s2", int'(bus.score_player_2), 0);
        check("restart_serving", int'(bus.serving), 1);
        check("restart_game_over", int'(bus.game_over), 0);

        // Random play against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            bus.frame_tick = 1'($urandom_range(0, 1));
            bus.restart = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 7);
                set_ball((r == 0) ? $urandom_range(0, 8) :
                         (r == 1) ? $urandom_range(600, 639) : $urandom_range(0, 639),
                         $urandom_range(0, 479), $urandom_range(1, 40), $urandom_range(1, 40));
                set_p1($urandom_range(0, 40), $urandom_range(0, 460),
                       $urandom_range(1, 20), $urandom_range(1, 80));
                set_p2($urandom_range(580, 639), $urandom_range(0, 460),
                       $urandom_range(1, 20), $urandom_range(1, 80));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
